// File: rtl/ex_pipe_mdu.sv
// ex_pipe_mdu: EX stage with forwarding, ALU, EX/MEM register and iterative mult/div unit (divide present only with EX_MDU_DIV_EN)
module ex_pipe_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_id_ex_data_1,
  input  logic [DATA_W-1:0] i_id_ex_data_2,
  input  logic [REG_AW-1:0] i_id_ex_rs,
  input  logic [REG_AW-1:0] i_id_ex_rt,
  input  logic [REG_AW-1:0] i_id_ex_rd,
  input  logic [DATA_W-1:0] i_id_ex_imm,
  input  logic [5:0]        i_id_ex_function_code,
  input  logic [3:0]        i_id_ex_alu_op,
  input  logic              i_id_ex_reg_dst,
  input  logic              i_id_ex_alu_src,
  input  logic              i_id_ex_mem_read,
  input  logic              i_id_ex_mem_write,
  input  logic              i_id_ex_mem_to_reg,
  input  logic              i_id_ex_reg_write,
  input  logic              i_id_ex_halt,
  input  logic [2:0]        i_id_ex_bhw_type,
  input  logic [2:0]        i_id_ex_mdu_op,
  input  logic [DATA_W-1:0] i_ex_m_alu_result,
  input  logic [DATA_W-1:0] i_m_wb_data_write,
  input  logic [REG_AW-1:0] i_ex_m_rd,
  input  logic [REG_AW-1:0] i_m_wb_rd,
  input  logic              i_ex_m_reg_write,
  input  logic              i_m_wb_reg_write,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_ex_m_alu_result,
  output logic [DATA_W-1:0] o_ex_m_write_data,
  output logic [REG_AW-1:0] o_ex_m_rd,
  output logic [2:0]        o_ex_m_bhw_type,
  output logic              o_ex_m_mem_read,
  output logic              o_ex_m_mem_write,
  output logic              o_ex_m_mem_to_reg,
  output logic              o_ex_m_reg_write,
  output logic              o_ex_m_halt,
  output logic              o_stall,
  output logic              o_illegal
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_y, mag_a, mag_b, hi, lo, acc, q, m;
  logic [DATA_W:0] sum;
  logic [2*DATA_W-1:0] res;
  logic [3:0] alu_ctl;
  logic [CW-1:0] cnt;
  logic is_mul, is_div, illegal_op, start, sgn, sa, sb, neg_lo;
`ifdef EX_MDU_DIV_EN
  logic [DATA_W:0] sh, diff;
  logic [DATA_W-1:0] a_raw;
  logic div_r, dz, neg_hi;
`endif
  assign fwd_a = i_ex_m_reg_write && |i_id_ex_rs && i_ex_m_rd == i_id_ex_rs ? i_ex_m_alu_result :
                 i_m_wb_reg_write && |i_id_ex_rs && i_m_wb_rd == i_id_ex_rs ? i_m_wb_data_write : i_id_ex_data_1;
  assign fwd_b = i_ex_m_reg_write && |i_id_ex_rt && i_ex_m_rd == i_id_ex_rt ? i_ex_m_alu_result :
                 i_m_wb_reg_write && |i_id_ex_rt && i_m_wb_rd == i_id_ex_rt ? i_m_wb_data_write : i_id_ex_data_2;
  assign alu_b = i_id_ex_alu_src ? i_id_ex_imm : fwd_b;
  always_comb begin
    alu_ctl = i_id_ex_alu_op;
    if (i_id_ex_alu_op == 4'd2)
      case (i_id_ex_function_code)
        6'h22, 6'h23: alu_ctl = 4'd1;
        6'h24: alu_ctl = 4'd3;
        6'h25: alu_ctl = 4'd4;
        6'h26: alu_ctl = 4'd5;
        6'h27: alu_ctl = 4'd9;
        6'h2a: alu_ctl = 4'd6;
        6'h2b: alu_ctl = 4'd7;
        6'h04: alu_ctl = 4'd10;
        6'h06: alu_ctl = 4'd11;
        6'h07: alu_ctl = 4'd12;
        default: alu_ctl = 4'd0;
      endcase
  end
  always_comb begin
    case (alu_ctl)
      4'd1: alu_y = fwd_a - alu_b;
      4'd3: alu_y = fwd_a & alu_b;
      4'd4: alu_y = fwd_a | alu_b;
      4'd5: alu_y = fwd_a ^ alu_b;
      4'd6: alu_y = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      4'd7: alu_y = {{(DATA_W-1){1'b0}}, fwd_a < alu_b};
      4'd8: alu_y = alu_b << (DATA_W/2);
      4'd9: alu_y = ~(fwd_a | alu_b);
      4'd10: alu_y = alu_b << fwd_a[CW-1:0];
      4'd11: alu_y = alu_b >> fwd_a[CW-1:0];
      4'd12: alu_y = $signed(alu_b) >>> fwd_a[CW-1:0];
      default: alu_y = fwd_a + alu_b;
    endcase
  end
  assign is_mul = i_id_ex_mdu_op == 3'd1 || i_id_ex_mdu_op == 3'd2;
`ifdef EX_MDU_DIV_EN
  assign is_div = i_id_ex_mdu_op == 3'd3 || i_id_ex_mdu_op == 3'd4;
  assign illegal_op = 1'b0;
`else
  assign is_div = 1'b0;
  assign illegal_op = i_id_ex_mdu_op == 3'd3 || i_id_ex_mdu_op == 3'd4;
`endif
  assign start = state == IDLE && (is_mul || is_div);
  assign o_stall = i_rst_n && !i_flush && (start || state == BUSY);
  assign sgn = i_id_ex_mdu_op == 3'd1 || i_id_ex_mdu_op == 3'd3;
  assign sa = sgn && fwd_a[DATA_W-1];
  assign sb = sgn && fwd_b[DATA_W-1];
  assign mag_a = sa ? -fwd_a : fwd_a;
  assign mag_b = sb ? -fwd_b : fwd_b;
  assign sum = {1'b0, acc} + {1'b0, q[0] ? m : {DATA_W{1'b0}}};
`ifdef EX_MDU_DIV_EN
  assign sh = {acc, q[DATA_W-1]};
  assign diff = sh - {1'b0, m};
`endif
  always_comb begin
    res = neg_lo ? -{acc, q} : {acc, q};
`ifdef EX_MDU_DIV_EN
    if (div_r) res = dz ? {a_raw, {DATA_W{1'b1}}} : {neg_hi ? -acc : acc, neg_lo ? -q : q};
`endif
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      {hi, lo, acc, q, m, cnt, neg_lo} <= '0;
`ifdef EX_MDU_DIV_EN
      {a_raw, div_r, dz, neg_hi} <= '0;
`endif
    end else if (i_flush) state <= IDLE;
    else
      case (state)
        IDLE: if (start) begin
          state <= BUSY;
          cnt <= '0;
          acc <= '0;
          q <= mag_a;
          m <= mag_b;
          neg_lo <= sa ^ sb;
`ifdef EX_MDU_DIV_EN
          a_raw <= fwd_a;
          div_r <= is_div;
          dz <= ~|fwd_b;
          neg_hi <= sa;
`endif
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(DATA_W-1) ? DONE : BUSY;
`ifdef EX_MDU_DIV_EN
          if (div_r) begin
            acc <= diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
            q <= {q[DATA_W-2:0], ~diff[DATA_W]};
          end else
`endif
          begin
            acc <= sum[DATA_W:1];
            q <= {sum[0], q[DATA_W-1:1]};
          end
        end
        DONE: begin
          {hi, lo} <= res;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_illegal <= 1'b0;
      {o_ex_m_alu_result, o_ex_m_write_data, o_ex_m_rd, o_ex_m_bhw_type, o_ex_m_mem_read, o_ex_m_mem_write,
       o_ex_m_mem_to_reg, o_ex_m_reg_write, o_ex_m_halt} <= '0;
    end else begin
      o_illegal <= !i_flush && state == IDLE && illegal_op;
      if (i_flush || o_stall || illegal_op)
        {o_ex_m_alu_result, o_ex_m_write_data, o_ex_m_rd, o_ex_m_bhw_type, o_ex_m_mem_read, o_ex_m_mem_write,
         o_ex_m_mem_to_reg, o_ex_m_reg_write, o_ex_m_halt} <= '0;
      else begin
        o_ex_m_alu_result <= i_id_ex_mdu_op == 3'd5 ? hi : i_id_ex_mdu_op == 3'd6 ? lo : alu_y;
        o_ex_m_write_data <= fwd_b;
        o_ex_m_rd <= i_id_ex_reg_dst ? i_id_ex_rd : i_id_ex_rt;
        o_ex_m_bhw_type <= i_id_ex_bhw_type;
        o_ex_m_mem_read <= i_id_ex_mem_read;
        o_ex_m_mem_write <= i_id_ex_mem_write;
        o_ex_m_mem_to_reg <= i_id_ex_mem_to_reg;
        o_ex_m_reg_write <= i_id_ex_reg_write && state != DONE;
        o_ex_m_halt <= i_id_ex_halt;
      end
    end
endmodule

// File: tb/tb_ex_pipe_mdu.sv
// tb_ex_pipe_mdu: directed checks of forwarding, ALU, mult/div timing, flush and reset for ex_pipe_mdu
module tb_ex_pipe_mdu;
  localparam int W = 32, A = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] d1, d2, imm, exm_res, wb_data, res, wdata;
  logic [A-1:0] rs, rt, rd, exm_rd, wb_rd, o_rd;
  logic [5:0] fn;
  logic [3:0] alu_op;
  logic [2:0] bhw, mdu_op, o_bhw;
  logic reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, halt, exm_rw, wb_rw, flush;
  logic o_mr, o_mw, o_m2r, o_rw, o_halt, stall, illegal;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  ex_pipe_mdu #(.DATA_W(W), .REG_AW(A)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_ex_data_1(d1), .i_id_ex_data_2(d2), .i_id_ex_rs(rs), .i_id_ex_rt(rt),
    .i_id_ex_rd(rd), .i_id_ex_imm(imm), .i_id_ex_function_code(fn), .i_id_ex_alu_op(alu_op),
    .i_id_ex_reg_dst(reg_dst), .i_id_ex_alu_src(alu_src), .i_id_ex_mem_read(mem_read),
    .i_id_ex_mem_write(mem_write), .i_id_ex_mem_to_reg(mem_to_reg), .i_id_ex_reg_write(reg_write),
    .i_id_ex_halt(halt), .i_id_ex_bhw_type(bhw), .i_id_ex_mdu_op(mdu_op), .i_ex_m_alu_result(exm_res),
    .i_m_wb_data_write(wb_data), .i_ex_m_rd(exm_rd), .i_m_wb_rd(wb_rd), .i_ex_m_reg_write(exm_rw),
    .i_m_wb_reg_write(wb_rw), .i_flush(flush), .o_ex_m_alu_result(res), .o_ex_m_write_data(wdata),
    .o_ex_m_rd(o_rd), .o_ex_m_bhw_type(o_bhw), .o_ex_m_mem_read(o_mr), .o_ex_m_mem_write(o_mw),
    .o_ex_m_mem_to_reg(o_m2r), .o_ex_m_reg_write(o_rw), .o_ex_m_halt(o_halt), .o_stall(stall),
    .o_illegal(illegal)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic clr;
    {d1, d2, imm, exm_res, wb_data, rs, rt, rd, exm_rd, wb_rd, fn, alu_op, bhw, mdu_op} = '0;
    {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, halt, exm_rw, wb_rw, flush} = '0;
  endtask
  task automatic run_mdu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n = 0;
    clr();
    mdu_op = op;
    d1 = a;
    d2 = b;
    reg_write = 1'b1;
    reg_dst = 1'b1;
    rd = 5'd9;
    #1;
    while (stall && n < 100) begin
      n++;
      step();
      if (n == 1) chk({tag, " bubble rw"}, o_rw, 0);
    end
    chk({tag, " stall cycles"}, n, 33);
    step();
    chk({tag, " retire rw"}, o_rw, 0);
  endtask
  task automatic rd_hl(input logic [2:0] op, input logic [W-1:0] exp, input string tag);
    clr();
    mdu_op = op;
    reg_write = 1'b1;
    #1;
    chk({tag, " stall"}, stall, 0);
    step();
    chk(tag, res, exp);
  endtask
  initial begin
    clr();
    mdu_op = 3'd1;
    #12;
    chk("reset stall", stall, 0);
    chk("reset res", res, 0);
    chk("reset rw", o_rw, 0);
    chk("reset illegal", illegal, 0);
    clr();
    rst_n = 1'b1;
    rs = 5'd4; rt = 5'd5; rd = 5'd7; d1 = 32'h99; d2 = 32'h3;
    exm_rw = 1'b1; exm_rd = 5'd4; exm_res = 32'h10; wb_rw = 1'b1; wb_rd = 5'd4; wb_data = 32'h20;
    reg_dst = 1'b1; reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; bhw = 3'b010; halt = 1'b1;
    step();
    chk("fwd exm priority", res, 32'h13);
    chk("rd dst", o_rd, 7);
    chk("rw pass", o_rw, 1);
    chk("mem_read pass", o_mr, 1);
    chk("mem_to_reg pass", o_m2r, 1);
    chk("bhw pass", o_bhw, 2);
    chk("halt pass", o_halt, 1);
    chk("store data", wdata, 32'h3);
    rs = 5'd0; exm_rd = 5'd0; wb_rd = 5'd0;
    step();
    chk("fwd rs zero", res, 32'h9c);
    rs = 5'd4; exm_rd = 5'd5; wb_rd = 5'd4; alu_op = 4'd1; reg_dst = 1'b0;
    step();
    chk("fwd wb a exm b sub", res, 32'h10);
    chk("fwd store data", wdata, 32'h10);
    chk("rd rt", o_rd, 5);
    clr();
    d1 = 32'h99; d2 = 32'h3; imm = 32'h100; alu_src = 1'b1; alu_op = 4'd4; mem_write = 1'b1;
    step();
    chk("ori imm", res, 32'h199);
    chk("imm store data", wdata, 32'h3);
    chk("mem_write pass", o_mw, 1);
    clr();
    alu_op = 4'd2; fn = 6'h2a; d1 = 32'hffffffff; d2 = 32'h1;
    step();
    chk("slt", res, 1);
    fn = 6'h2b;
    step();
    chk("sltu", res, 0);
    run_mdu(3'd1, 32'hfffffffd, 32'h5, "mult");
    rd_hl(3'd5, 32'hffffffff, "mult hi");
    rd_hl(3'd6, 32'hfffffff1, "mult lo");
    run_mdu(3'd2, 32'hffffffff, 32'hffffffff, "multu");
    rd_hl(3'd5, 32'hfffffffe, "multu hi");
    rd_hl(3'd6, 32'h00000001, "multu lo");
    clr();
    mdu_op = 3'd1; d1 = 32'h2; d2 = 32'h3; reg_write = 1'b1;
    step();
    repeat (9) step();
    chk("busy stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("flush stall", stall, 0);
    step();
    chk("flush bubble rw", o_rw, 0);
    rd_hl(3'd5, 32'hfffffffe, "flush keeps hi");
    rd_hl(3'd6, 32'h00000001, "flush keeps lo");
    clr();
    mdu_op = 3'd1; d1 = 32'h2; d2 = 32'h3; reg_write = 1'b1; flush = 1'b1;
    #1;
    chk("flush over start stall", stall, 0);
    step();
    chk("flush over start rw", o_rw, 0);
    rd_hl(3'd6, 32'h00000001, "flush over start lo");
`ifdef EX_MDU_DIV_EN
    run_mdu(3'd3, 32'hfffffff9, 32'h2, "div");
    rd_hl(3'd6, 32'hfffffffd, "div lo");
    rd_hl(3'd5, 32'hffffffff, "div hi");
    run_mdu(3'd4, 32'h7, 32'h0, "divu0");
    rd_hl(3'd6, 32'hffffffff, "divu0 lo");
    rd_hl(3'd5, 32'h7, "divu0 hi");
    run_mdu(3'd3, 32'h80000000, 32'hffffffff, "divmin");
    rd_hl(3'd6, 32'h80000000, "divmin lo");
    rd_hl(3'd5, 32'h0, "divmin hi");
`else
    clr();
    mdu_op = 3'd4; d1 = 32'h7; d2 = 32'h1; reg_write = 1'b1;
    #1;
    chk("divu nodiv stall", stall, 0);
    step();
    chk("divu illegal", illegal, 1);
    chk("divu bubble rw", o_rw, 0);
    clr();
    step();
    chk("illegal one cycle", illegal, 0);
    rd_hl(3'd5, 32'hfffffffe, "divu keeps hi");
`endif
    clr();
    d1 = 32'h40; d2 = 32'h2; reg_write = 1'b1;
    step();
    chk("pre reset res", res, 32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset res", res, 0);
    chk("async reset rw", o_rw, 0);
    #1;
    rst_n = 1'b1;
    clr();
    mdu_op = 3'd1; d1 = 32'h5; d2 = 32'h5;
    step();
    step();
    chk("busy before reset", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("reset mid busy stall", stall, 0);
    chk("reset mid busy rw", o_rw, 0);
    clr();
    #2;
    rst_n = 1'b1;
    step();
    chk("after reset stall", stall, 0);
    rd_hl(3'd5, 32'h0, "reset hi");
    rd_hl(3'd6, 32'h0, "reset lo");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
